// File: rtl/uart_pkg.sv
// Shared UART definitions: Rx FSM state encoding and frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    BITS      = 2'd2,
    WAIT_IDLE = 2'd3
  } rx_state_e;

  // Bits strobed after the start bit: data + optional parity + stop bits.
  function automatic int frame_len(input int data_width, input int parity_enabled,
                                   input int stop_bits);
    return data_width + parity_enabled + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with mid-bit and end-of-bit ticks; shared by the Rx and Tx paths.
module uart_bit_timer #(
  parameter int  CLOCKS_PER_BIT = 5000,
  localparam int CW             = $clog2(CLOCKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF = CLOCKS_PER_BIT / 2;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= full_tick ? '0 : cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == CW'(HALF - 1));
  assign full_tick = (cnt == CW'(CLOCKS_PER_BIT - 1));

`ifdef FORMAL
  always_comb assert (int'(cnt) < CLOCKS_PER_BIT);
`endif

endmodule

// File: rtl/uart_rx_frame_timer.sv
// UART Rx front end: start-bit qualification, bit-centre strobes, bit indexing and stop-bit checks.
module uart_rx_frame_timer
  import uart_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  PARITY_ENABLED = 1,
  parameter int  STOP_BITS      = 1,
  parameter int  CLOCKS_PER_BIT = 5000,
  localparam int N              = frame_len(DATA_WIDTH, PARITY_ENABLED, STOP_BITS),
  localparam int BIW            = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           serial_in_synced,
  input  logic           enable,
  output logic           start_detected,
  output logic           false_start,
  output logic           sample_strobe,
  output logic [BIW-1:0] bit_index,
  output logic           sample_bit,
  output logic           frame_active,
  output logic           frame_done,
  output logic           framing_error
);

  localparam int STOP_FIRST = DATA_WIDTH + PARITY_ENABLED;

  if (CLOCKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_frame_timer: CLOCKS_PER_BIT must be >= 4");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_frame_timer: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data
    $error("uart_rx_frame_timer: DATA_WIDTH must be 5..9");
  end

  rx_state_e      state, state_next;
  logic           prev_line, falling;
  logic           half_tick, full_tick, timer_clear;
  logic [BIW-1:0] bit_cnt;
  logic           start_d, false_d, strobe_d, done_d, ferr_d;

  assign falling     = !serial_in_synced && prev_line;
  // Timer restarts from zero on every state change and is held idle outside the frame.
  assign timer_clear = (state_next != state) || (state == IDLE) || (state == WAIT_IDLE);

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (enable),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    state_next = state;
    start_d    = 1'b0;
    false_d    = 1'b0;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (falling) state_next = START_CHK;
        START_CHK: begin
          if (half_tick) begin
            if (!serial_in_synced) begin
              start_d    = 1'b1;
              state_next = BITS;
            end else begin
              false_d    = 1'b1;
              state_next = IDLE;
            end
          end
        end
        BITS: begin
          if (full_tick) begin
            strobe_d = 1'b1;
            if (bit_cnt >= BIW'(STOP_FIRST)) begin
              if (!serial_in_synced) begin
                ferr_d     = 1'b1;
                state_next = WAIT_IDLE;
              end else if (bit_cnt == BIW'(N - 1)) begin
                done_d     = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
        WAIT_IDLE: if (serial_in_synced) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prev_line      <= 1'b0;
      bit_cnt        <= '0;
      start_detected <= 1'b0;
      false_start    <= 1'b0;
      sample_strobe  <= 1'b0;
      bit_index      <= '0;
      sample_bit     <= 1'b0;
      frame_active   <= 1'b0;
      frame_done     <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      state          <= state_next;
      prev_line      <= serial_in_synced;
      start_detected <= start_d;
      false_start    <= false_d;
      sample_strobe  <= strobe_d;
      frame_done     <= done_d;
      framing_error  <= ferr_d;
      // Held high through the cycle that carries the terminating pulse.
      frame_active   <= (state_next == START_CHK) || (state_next == BITS) ||
                        false_d || done_d || ferr_d;
      if (start_d) begin
        bit_cnt   <= '0;
        bit_index <= '0;
      end
      if (strobe_d) begin
        bit_index  <= bit_cnt;
        sample_bit <= serial_in_synced;
        if (bit_cnt != BIW'(N - 1)) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef FORMAL
  rx_state_e state_q1;
  logic      past_valid;
  always_ff @(posedge clk) begin
    state_q1   <= state;
    past_valid <= !reset;
  end
  always_comb begin
    assert ($onehot0({frame_done, framing_error, false_start}));
    if (past_valid && sample_strobe) assert (state_q1 != IDLE && state_q1 != START_CHK);
    if (past_valid && start_detected) assert (state_q1 == START_CHK);
  end
`endif

endmodule
